// File: rtl/mcu_vote_poller.sv
// ============================================================================
// Module   : mcu_vote_poller
// Brief    : Sequenced req/ack poller for redundant voter MCUs; collects fail
//            votes, flags silent voters and produces a threshold verdict.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcu_vote_poller #(
   parameter int  MAX_VOTERS     = 8,
   parameter int  TIMEOUT_CYCLES = 15,
   localparam int IDX_W          = (MAX_VOTERS > 1) ? $clog2(MAX_VOTERS) : 1,
   localparam int CNT_W          = $clog2(MAX_VOTERS + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [3:0]            num_voters,
   input  logic [2:0]            fails_okay,
   output logic                  poll_req,
   output logic [IDX_W-1:0]      poll_sel,
   input  logic                  vote_ack,
   input  logic                  vote_bit,
   output logic                  busy,
   output logic                  done,
   output logic [MAX_VOTERS-1:0] fail_vec,
   output logic [MAX_VOTERS-1:0] timeout_vec,
   output logic [CNT_W-1:0]      fail_count,
   output logic                  verdict
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_POLL = 2'd1;
   localparam logic [1:0] c_GAP  = 2'd2;
   localparam logic [1:0] c_DONE = 2'd3;

   localparam logic [3:0] c_TMO_LAST = 4'(TIMEOUT_CYCLES - 1);

   logic [1:0]            r_state;
   logic [IDX_W-1:0]      r_idx;
   logic [3:0]            r_timer;
   logic [CNT_W-1:0]      r_n;
   logic [2:0]            r_thr;
   logic [MAX_VOTERS-1:0] r_fail_vec;
   logic [MAX_VOTERS-1:0] r_timeout_vec;
   logic [CNT_W-1:0]      r_fail_count;
   logic                  r_verdict;
   logic [CNT_W-1:0]      w_n_clamp;
   logic                  w_last_voter;

   assign w_n_clamp    = (num_voters > 4'(MAX_VOTERS)) ? CNT_W'(MAX_VOTERS)
                                                       : CNT_W'(num_voters);
   assign w_last_voter = (CNT_W'(r_idx) == (r_n - CNT_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= c_IDLE;
         r_idx         <= '0;
         r_timer       <= '0;
         r_n           <= '0;
         r_thr         <= '0;
         r_fail_vec    <= '0;
         r_timeout_vec <= '0;
         r_fail_count  <= '0;
         r_verdict     <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_n           <= w_n_clamp;
                  r_thr         <= fails_okay;
                  r_fail_vec    <= '0;
                  r_timeout_vec <= '0;
                  r_fail_count  <= '0;
                  r_verdict     <= 1'b0;
                  r_idx         <= '0;
                  r_timer       <= '0;
                  r_state       <= (w_n_clamp == '0) ? c_DONE : c_POLL;
               end
            end
            c_POLL: begin
               r_timer <= r_timer + 4'd1;
               // An ack on the final timeout cycle still counts as a real vote.
               if (vote_ack) begin
                  r_fail_vec[r_idx] <= vote_bit;
                  r_fail_count      <= r_fail_count + CNT_W'(vote_bit);
                  r_state           <= c_GAP;
               end else if (r_timer == c_TMO_LAST) begin
                  r_fail_vec[r_idx]    <= 1'b1;
                  r_timeout_vec[r_idx] <= 1'b1;
                  r_fail_count         <= r_fail_count + CNT_W'(1);
                  r_state              <= c_GAP;
               end
            end
            c_GAP: begin
               if (w_last_voter) begin
                  r_verdict <= (r_fail_count > CNT_W'(r_thr));
                  r_state   <= c_DONE;
               end else begin
                  r_idx   <= r_idx + IDX_W'(1);
                  r_timer <= '0;
                  r_state <= c_POLL;
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign poll_req    = (r_state == c_POLL);
   assign poll_sel    = r_idx;
   assign busy        = (r_state != c_IDLE);
   assign done        = (r_state == c_DONE);
   assign fail_vec    = r_fail_vec;
   assign timeout_vec = r_timeout_vec;
   assign fail_count  = r_fail_count;
   assign verdict     = r_verdict;

endmodule

`default_nettype wire

// File: tb/tb_mcu_vote_poller.sv
// ============================================================================
// Module   : tb_mcu_vote_poller
// Brief    : Directed self-checking bench for mcu_vote_poller with a
//            scripted voter responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcu_vote_poller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] num_voters = '0;
   logic [2:0] fails_okay = '0;
   logic       poll_req;
   logic [2:0] poll_sel;
   logic       vote_ack = 1'b0;
   logic       vote_bit = 1'b0;
   logic       busy;
   logic       done;
   logic [7:0] fail_vec;
   logic [7:0] timeout_vec;
   logic [3:0] fail_count;
   logic       verdict;

   int checks = 0;
   int failures = 0;

   mcu_vote_poller #(.MAX_VOTERS(8), .TIMEOUT_CYCLES(15)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_voters(num_voters),
      .fails_okay(fails_okay), .poll_req(poll_req), .poll_sel(poll_sel),
      .vote_ack(vote_ack), .vote_bit(vote_bit), .busy(busy), .done(done),
      .fail_vec(fail_vec), .timeout_vec(timeout_vec),
      .fail_count(fail_count), .verdict(verdict)
   );

   always #5 clk = ~clk;

   // Voter responder: per-voter vote and ack delay (in POLL cycles, 255 = never)
   logic [7:0] cfg_vote = '0;
   int         cfg_delay[8];
   bit         spurious = 1'b0;
   int         req_cnt[8];
   int         rises = 0;
   int         glitches = 0;
   logic [7:0] polled = '0;
   logic       prev_req = 1'b0;
   logic [2:0] prev_sel = '0;
   int         cnt = 0;

   always begin
      @(posedge clk);
      #1;
      if (poll_req === 1'b1) begin
         if (prev_req !== 1'b1) begin
            cnt = 0;
            rises++;
         end else begin
            cnt++;
            if (poll_sel !== prev_sel) glitches++;
         end
         req_cnt[poll_sel]++;
         polled[poll_sel] = 1'b1;
         vote_ack = (cnt == cfg_delay[poll_sel]);
         vote_bit = cfg_vote[poll_sel];
      end else begin
         vote_ack = spurious;
         vote_bit = spurious;
      end
      prev_req = poll_req;
      prev_sel = poll_sel;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setup(input logic [7:0] votes, input int delay_all);
      cfg_vote = votes;
      for (int i = 0; i < 8; i++) begin
         cfg_delay[i] = delay_all;
         req_cnt[i]   = 0;
      end
      rises = 0;
      glitches = 0;
      polled = '0;
   endtask

   task automatic start_round(input logic [3:0] nv, input logic [2:0] fo);
      num_voters = nv;
      fails_okay = fo;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int c0, output int cyc);
      cyc = c0;
      while (done !== 1'b1 && cyc < 300) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({poll_req, busy, done, verdict} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ctrl: got req/busy/done/verdict=%b expected 0000",
                  {poll_req, busy, done, verdict});
      end
      checks++;
      if ({poll_sel, fail_vec, timeout_vec, fail_count} !== 23'd0) begin
         failures++;
         $display("FAIL reset_data: got sel=%0d fv=%h tv=%h fc=%0d expected all 0",
                  poll_sel, fail_vec, timeout_vec, fail_count);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int cyc;
      setup(8'b0000_1010, 0);
      start_round(4'd5, 3'd1);
      wait_done(1, cyc);
      checks++;
      if (cyc !== 11) begin
         failures++;
         $display("FAIL basic_latency: got %0d expected 11", cyc);
      end
      checks++;
      if ({fail_vec, timeout_vec, fail_count, verdict} !== {8'h0A, 8'h00, 4'd2, 1'b1}) begin
         failures++;
         $display("FAIL basic_result: got fv=%h tv=%h fc=%0d v=%b expected 0a 00 2 1",
                  fail_vec, timeout_vec, fail_count, verdict);
      end
      checks++;
      if (rises !== 5 || polled !== 8'h1F || glitches !== 0) begin
         failures++;
         $display("FAIL basic_polls: got rises=%0d polled=%h glitches=%0d expected 5 1f 0",
                  rises, polled, glitches);
      end
      tick();
      checks++;
      if ({busy, done} !== 2'b00 || fail_vec !== 8'h0A || verdict !== 1'b1) begin
         failures++;
         $display("FAIL basic_hold: got busy=%b done=%b fv=%h v=%b expected 0 0 0a 1",
                  busy, done, fail_vec, verdict);
      end
   endtask

   task automatic test_empty();
      int cyc;
      setup(8'h00, 0);
      start_round(4'd0, 3'd0);
      wait_done(1, cyc);
      checks++;
      if (cyc !== 1) begin
         failures++;
         $display("FAIL empty_latency: got %0d expected 1", cyc);
      end
      checks++;
      if ({fail_vec, fail_count, verdict, rises[3:0]} !== 17'd0) begin
         failures++;
         $display("FAIL empty_result: got fv=%h fc=%0d v=%b rises=%0d expected 0 0 0 0",
                  fail_vec, fail_count, verdict, rises);
      end
      tick();
   endtask

   task automatic test_timeout();
      int cyc;
      setup(8'h00, 0);
      cfg_delay[2] = 255;
      start_round(4'd3, 3'd1);
      wait_done(1, cyc);
      checks++;
      if (cyc !== 21 || req_cnt[2] !== 15) begin
         failures++;
         $display("FAIL timeout_timing: got cyc=%0d req_cycles=%0d expected 21 15",
                  cyc, req_cnt[2]);
      end
      checks++;
      if ({fail_vec, timeout_vec, fail_count, verdict} !== {8'h04, 8'h04, 4'd1, 1'b0}) begin
         failures++;
         $display("FAIL timeout_result: got fv=%h tv=%h fc=%0d v=%b expected 04 04 1 0",
                  fail_vec, timeout_vec, fail_count, verdict);
      end
      tick();
   endtask

   task automatic test_ack_boundary();
      int cyc;
      setup(8'h00, 14);
      start_round(4'd1, 3'd0);
      wait_done(1, cyc);
      checks++;
      if (cyc !== 17 || req_cnt[0] !== 15) begin
         failures++;
         $display("FAIL ackbnd_timing: got cyc=%0d req_cycles=%0d expected 17 15",
                  cyc, req_cnt[0]);
      end
      checks++;
      if ({fail_vec, timeout_vec, fail_count, verdict} !== {8'h00, 8'h00, 4'd0, 1'b0}) begin
         failures++;
         $display("FAIL ackbnd_result: got fv=%h tv=%h fc=%0d v=%b expected 00 00 0 0",
                  fail_vec, timeout_vec, fail_count, verdict);
      end
      tick();
   endtask

   task automatic test_clamp();
      int cyc;
      setup(8'hFF, 0);
      start_round(4'd12, 3'd7);
      wait_done(1, cyc);
      checks++;
      if (cyc !== 17 || polled !== 8'hFF || rises !== 8) begin
         failures++;
         $display("FAIL clamp_polls: got cyc=%0d polled=%h rises=%0d expected 17 ff 8",
                  cyc, polled, rises);
      end
      checks++;
      if ({fail_vec, fail_count, verdict} !== {8'hFF, 4'd8, 1'b1}) begin
         failures++;
         $display("FAIL clamp_result: got fv=%h fc=%0d v=%b expected ff 8 1",
                  fail_vec, fail_count, verdict);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int cyc;
      setup(8'b0000_0011, 0);
      spurious = 1'b1;
      start_round(4'd4, 3'd2);
      tick();
      tick();
      num_voters = 4'd1;
      fails_okay = 3'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(4, cyc);
      checks++;
      if (cyc !== 9 || rises !== 4) begin
         failures++;
         $display("FAIL busy_start_timing: got cyc=%0d rises=%0d expected 9 4", cyc, rises);
      end
      checks++;
      if ({fail_vec, timeout_vec, fail_count, verdict} !== {8'h03, 8'h00, 4'd2, 1'b0}) begin
         failures++;
         $display("FAIL busy_start_result: got fv=%h tv=%h fc=%0d v=%b expected 03 00 2 0",
                  fail_vec, timeout_vec, fail_count, verdict);
      end
      spurious = 1'b0;
      tick();
      tick();
      checks++;
      if ({busy, done} !== 2'b00) begin
         failures++;
         $display("FAIL busy_start_idle: got busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   task automatic test_reset_mid();
      int k;
      int cyc;
      setup(8'hFF, 0);
      start_round(4'd6, 3'd0);
      k = 0;
      while (!(poll_req === 1'b1 && poll_sel === 3'd3) && k < 100) begin
         tick();
         k++;
      end
      checks++;
      if (k >= 100) begin
         failures++;
         $display("FAIL rstmid_reach: got no poll of voter 3 expected one within 100 cycles");
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({poll_req, busy, done, poll_sel, fail_vec, timeout_vec, fail_count, verdict} !== 27'd0) begin
         failures++;
         $display("FAIL rstmid_clear: got req=%b busy=%b done=%b sel=%0d fv=%h tv=%h fc=%0d v=%b expected all 0",
                  poll_req, busy, done, poll_sel, fail_vec, timeout_vec, fail_count, verdict);
      end
      #2 rst_n = 1'b1;
      tick();
      tick();
      checks++;
      if ({busy, done} !== 2'b00) begin
         failures++;
         $display("FAIL rstmid_idle: got busy=%b done=%b expected 0 0", busy, done);
      end
      setup(8'b0000_0001, 0);
      start_round(4'd2, 3'd0);
      wait_done(1, cyc);
      checks++;
      if (cyc !== 5 || {fail_vec, timeout_vec, fail_count, verdict} !== {8'h01, 8'h00, 4'd1, 1'b1}) begin
         failures++;
         $display("FAIL rstmid_rerun: got cyc=%0d fv=%h tv=%h fc=%0d v=%b expected 5 01 00 1 1",
                  cyc, fail_vec, timeout_vec, fail_count, verdict);
      end
      tick();
   endtask

   initial begin
      setup(8'h00, 0);
      test_reset();
      test_basic();
      test_empty();
      test_timeout();
      test_ack_boundary();
      test_clamp();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected finish before 200000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
